// File: rtl/spike_config_decoder.sv
// Flit decoder: spike accumulation plus sequenced 64-bit config writes into Neuron.
// Optional drop counter under DECODER_DROP_CNT_EN (tied to zero when undefined).
module spike_config_decoder #(
  parameter int FLIT_WIDTH         = 38,
  parameter int NURN_CNT_BIT_WIDTH = 2,
  parameter int AXON_CNT_BIT_WIDTH = 2,
  parameter int NUM_MEMS           = 12
) (
  input  logic                          neuron_clk,
  input  logic                          neuron_rst,
  input  logic                          start,
  input  logic [FLIT_WIDTH-1:0]         flit_to_decoder,
  input  logic                          activate_decoder,
  output logic                          stall_decoder,
  output logic [(1<<AXON_CNT_BIT_WIDTH)-1:0] spike_array,
  output logic [NUM_MEMS-1:0]           wr_en,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] wr_address,
  output logic [63:0]                   config_data,
  output logic [15:0]                   drop_count
);
  localparam int AW = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
  localparam int SW = 1 << AXON_CNT_BIT_WIDTH;
  localparam logic [4:0] NMEM = 5'(NUM_MEMS);

  typedef enum logic [1:0] {
    S_IDLE, S_LO, S_HI, S_WR
  } st_e;

  st_e             state_q, state_d;
  logic [3:0]      msel_q, msel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     lo_q, lo_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [63:0]     wd_q, wd_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [SW-1:0]   spk_q, spk_d;
  logic [1:0]      drop_inc;

  logic [1:0]      ftype;
  logic [31:0]     pay;
  logic            take, f_single, f_head, f_body, f_tail;
  logic            head_ok, msel_ok;

  assign ftype    = flit_to_decoder[37:36];
  assign pay      = flit_to_decoder[31:0];
  assign take     = activate_decoder && (state_q != S_WR);
  assign f_single = take && (ftype == 2'b11);
  assign f_head   = take && (ftype == 2'b10);
  assign f_body   = take && (ftype == 2'b00);
  assign f_tail   = take && (ftype == 2'b01);
  assign head_ok  = (pay[31:28] == 4'h1);
  assign msel_ok  = ({1'b0, msel_q} < NMEM);

  logic unused_flit;
  assign unused_flit = ^flit_to_decoder;

  always_ff @(posedge neuron_clk) begin
    if (neuron_rst) begin
      state_q <= S_IDLE;
      msel_q  <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      acc_q   <= '0;
      spk_q   <= '0;
    end else begin
      state_q <= state_d;
      msel_q  <= msel_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      acc_q   <= acc_d;
      spk_q   <= spk_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    msel_d   = msel_q;
    addr_d   = addr_q;
    lo_d     = lo_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
    drop_inc = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        if (f_head) begin
          if (head_ok) begin
            state_d = S_LO;
            msel_d  = pay[27:24];
            addr_d  = pay[AW-1:0];
          end else begin
            drop_inc = 2'd1;
          end
        end else if (f_body || f_tail) begin
          drop_inc = 2'd1;
        end
      end
      S_LO, S_HI: begin
        if (f_head) begin
          // A new head aborts the packet in flight and may itself be dropped
          if (head_ok) begin
            drop_inc = 2'd1;
            state_d  = S_LO;
            msel_d   = pay[27:24];
            addr_d   = pay[AW-1:0];
          end else begin
            drop_inc = 2'd2;
            state_d  = S_IDLE;
          end
        end else if (state_q == S_LO && f_body) begin
          lo_d    = pay;
          state_d = S_HI;
        end else if (state_q == S_HI && f_tail) begin
          if (msel_ok) begin
            wa_d    = addr_q;
            wd_d    = {pay, lo_q};
            state_d = S_WR;
          end else begin
            drop_inc = 2'd1;
            state_d  = S_IDLE;
          end
        end else if (f_body || f_tail) begin
          drop_inc = 2'd1;
          state_d  = S_IDLE;
        end
      end
      S_WR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A spike in the start cycle belongs to the next step
  always_comb begin
    acc_d = start ? '0 : acc_q;
    spk_d = start ? acc_q : spk_q;
    if (f_single) acc_d[pay[AXON_CNT_BIT_WIDTH-1:0]] = 1'b1;
  end

  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_MEMS; i++) begin
      wr_en[i] = (state_q == S_WR) && (msel_q == 4'(i));
    end
    stall_decoder = (state_q == S_WR);
    spike_array   = spk_q;
    wr_address    = wa_q;
    config_data   = wd_q;
  end

`ifdef DECODER_DROP_CNT_EN
  logic [15:0] drop_q;
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_q} + {15'b0, drop_inc};
  always_ff @(posedge neuron_clk) begin
    if (neuron_rst) drop_q <= '0;
    else            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
  assign drop_count = drop_q;
`else
  logic unused_drop;
  assign unused_drop = ^drop_inc;
  assign drop_count  = '0;
`endif

endmodule

// File: doc/spike_config_decoder.md
Name: spike_config_decoder

Overview:
- Sits between network_interface and Neuron inside neuron_tile; consumes decoded flits (flit_to_decoder / activate_decoder) and either accumulates incoming spikes into the per-step axon spike vector or sequences 64-bit configuration writes into Neuron's status/config memories.
- Owns backpressure to the NI (stall_decoder) and the one-hot memory write strobes, address and data driving Neuron's config port.

Parameters:
FLIT_WIDTH, 38, flit width; [37:36] flit type, [35:32] VC (ignored), [31:0] payload
NURN_CNT_BIT_WIDTH, 2, neuron address bits
AXON_CNT_BIT_WIDTH, 2, axon address bits; spike vector width = 1<<AXON_CNT_BIT_WIDTH
NUM_MEMS, 12, number of write targets (one-hot strobe width)

Ports:
neuron_clk  in  1  clock
neuron_rst  in  1  synchronous active-high reset
start  in  1  step boundary pulse from tile
flit_to_decoder  in  FLIT_WIDTH  flit from NI
activate_decoder  in  1  flit valid
stall_decoder  out  1  decoder busy; flit not consumed while high
spike_array  out  1<<AXON_CNT_BIT_WIDTH  spike vector for current step, to Neuron inSpike
wr_en  out  NUM_MEMS  one-hot write strobe; bit order: potential, threshold, bias, posthistory, prehistory, weight, configA, configB, AER, axonmode, scaling, coreconfig
wr_address  out  NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH  write address
config_data  out  64  write data
drop_count  out  16  dropped-packet count (see Optional Feature)

Behaviour:
- Flit accepted in a cycle with activate_decoder=1 and stall_decoder=0. Flit types: 2'b11 single, 2'b10 head, 2'b00 body, 2'b01 tail.
- Single flit = spike: sets bit payload[AXON_CNT_BIT_WIDTH-1:0] of the accumulator; accepted in any state and does not disturb an in-progress config packet.
- Head payload: [31:28] class (4'h1 = config; any other value drops the packet), [27:24] mem_sel (0..11 valid, 12..15 invalid), [NURN+AXON-1:0] address.
- FSM states:
  - IDLE: head with class 1 -> CFG_LO, mem_sel and address latched.
  - CFG_LO: body -> data[31:0] latched, go to CFG_HI.
  - CFG_HI: tail -> data[63:32] latched, go to WRITE.
  - WRITE: exactly one cycle; wr_en[mem_sel]=1, wr_address and config_data valid; stall_decoder=1; then IDLE.
- Invalid mem_sel: packet walks CFG_LO/CFG_HI normally; WRITE is skipped (no strobe); drop counted.
- Protocol errors:
  - body/tail in IDLE: dropped.
  - head in CFG_LO/CFG_HI: aborts the current packet (counted as a drop) and restarts with the new head.
  - tail in CFG_LO, or body in CFG_HI: abort -> IDLE, counted as a drop.
- Spike double buffer: on start=1, spike_array <= accumulator and accumulator <= 0. A spike accepted in the same cycle as start lands in the cleared accumulator, i.e. it belongs to the next step.
- wr_en is zero outside WRITE. wr_address/config_data hold their last value.
- Reset values: all outputs 0; accumulator 0; FSM IDLE. Reset mid-packet discards the partial packet with no strobe.
- Throughput: a config packet occupies 4 cycles minimum (3 flits + WRITE); stall_decoder is high only in WRITE.

Optional Feature:
- Macro DECODER_DROP_CNT_EN.
- Defined: drop_count increments by 1 on each dropped/aborted packet (invalid class, invalid mem_sel, stray body/tail, protocol abort) and saturates at 16'hFFFF.
- Undefined: the counter is not built and drop_count is tied to 0. Decode behaviour is identical in both builds.

Test Plan:
- Config write: head(class 1, mem_sel 5, addr 4'hA), body 32'h1234_5678, tail 32'h9ABC_DEF0 on back-to-back cycles -> cycle 4: wr_en=12'h020, wr_address=4'hA, config_data=64'h9ABCDEF0_12345678, stall_decoder=1. Next head is accepted the following cycle.
- Spike step: single flits axon 1 and 3, then start -> spike_array=4'b1010 the cycle after start. A spike on axon 0 in the start cycle -> next start gives 4'b0001.
- Interleave: head, single(axon 2), body, tail -> config write completes correctly; accumulator bit 2 set.
- Errors (with DECODER_DROP_CNT_EN): stray tail in IDLE, mem_sel 13 packet, head-head-body-tail sequence -> drop_count=3, only one wr_en pulse (from the second head). Without the macro, drop_count stays 0.
- Reset in CFG_HI: neuron_rst for one cycle, then tail -> no wr_en, FSM IDLE, spike_array=0.
- Stall: activate_decoder held high with a head during WRITE -> head is not consumed until the cycle after WRITE.
